uart_frame_rx: RTL and testbench

Buffered serial-frame receiver for the TX line driven by the UART transmit engine. It uses the same frame configuration: `eight`, `pen`, `ohel` and the bit-time count `k`. It recovers bytes at mid-bit and checks parity and stop bit. Each byte is pushed, with its error flags, into a small FIFO that the processor port logic pops. It sits between an external `rx` pin, or a loopback of `tx`, and the port-mapped read path.

---
 rtl/uart_frame_rx_if.sv | 13 +
 rtl/uart_frame_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_rx_if.sv
// Read-side bundle between the frame receiver FIFO and the processor port logic.
// The master pops with rd; the slave (receiver) presents the FIFO head and status flags.
interface uart_frame_rx_if;
    logic       rd;
    logic [7:0] data;
    logic       rxrdy;
    logic       ferr;
    logic       perr;
    logic       ovf;

    modport master (output rd, input data, rxrdy, ferr, perr, ovf);
    modport slave  (input rd, output data, rxrdy, ferr, perr, ovf);
endinterface

// File: rtl/uart_frame_rx.sv
// Serial frame receiver: mid-bit sampling, parity/stop checks, and a small FIFO of
// {ferr, perr, data} entries popped through the read-side interface.
module uart_frame_rx #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic [18:0]      k,
    uart_frame_rx_if.slave   bus,
    output logic [2:0]       fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta, rx_s, rx_prev;
    logic        eight_q, pen_q, ohel_q;
    logic [18:0] k_q;
    logic [18:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        perr_q;

    logic        start_det, cnt_clr, shift_en, par_en, push;
    logic        tick_half, tick_bit;
    logic [7:0]  data_byte;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          pop, full, wr_en, ovf_set, nonempty;
    logic [9:0]    head;

    // Two-flop synchronizer plus one more stage for start-edge detection; all idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
            k_q     <= '0;
        end else if (start_det) begin
            eight_q <= eight;
            pen_q   <= pen;
            ohel_q  <= ohel;
            k_q     <= k;
        end
    end

    assign tick_half = (cnt_q == (k_q >> 1) - 19'd1);
    assign tick_bit  = (cnt_q == k_q - 19'd1);
    // 7-bit frames leave the data in the upper seven bits of the right-shifting register.
    assign data_byte = eight_q ? shift_q : {1'b0, shift_q[7:1]};

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (rx_prev && !rx_s) begin
                    start_det = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (tick_half) begin
                    cnt_clr = 1'b1;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_bit) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_q == (eight_q ? 3'd7 : 3'd6))
                        state_d = pen_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick_bit) begin
                    cnt_clr = 1'b1;
                    par_en  = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick_bit) begin
                    cnt_clr = 1'b1;
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_clr ? '0 : cnt_q + 19'd1;
            if (start_det) begin
                bit_q  <= '0;
                perr_q <= 1'b0;
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[7:1]};
                bit_q   <= bit_q + 3'd1;
            end
            if (par_en)
                perr_q <= rx_s ^ (^data_byte) ^ ohel_q;
        end
    end

    assign fsm_state = state_q;

    // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
    assign pop     = bus.rd && (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[wr_ptr] <= {~rx_s, perr_q, data_byte};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(pop);
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (pop)
                ovf_q <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr];
    assign nonempty  = (count_q != '0) && !reset;
    assign bus.rxrdy = nonempty;
    assign bus.data  = nonempty ? head[7:0] : 8'h00;
    assign bus.perr  = nonempty ? head[8] : 1'b0;
    assign bus.ferr  = nonempty ? head[9] : 1'b0;
    assign bus.ovf   = ovf_q && !reset;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: frame timing, parity/framing errors, false start,
// FIFO overflow, simultaneous push/pop when full, and reset mid-frame.
module tb_uart_frame_rx;
    localparam int K = 16;

    logic        clk = 1'b0;
    logic        reset, rx, eight, pen, ohel;
    logic [18:0] k;
    logic [2:0]  fsm_state;

    uart_frame_rx_if bus();

    uart_frame_rx #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .eight     (eight),
        .pen       (pen),
        .ohel      (ohel),
        .k         (k),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock/reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int rise_cyc = -1;
    bit watch    = 1'b0;
    logic [7:0] exp_q[$];

    always @(negedge clk)
        if (watch && bus.rxrdy && rise_cyc < 0) rise_cyc = cyc;

    // Driver tasks: every task leaves time at 1 unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        rx = 1'b0;
        step(K);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            step(K);
        end
        if (with_par) begin
            rx = par_bit;
            step(K);
        end
        rx = stop_bit;
        step(K);
    endtask

    task automatic pop_one();
        bus.rd = 1'b1;
        step(1);
        bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; bus.rd = 1'b0;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; k = 19'(K);
        step(3);
        n_checks++; if (bus.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.data); end
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL reset_rxrdy: got %b expected 0", bus.rxrdy); end
        n_checks++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", bus.ferr); end
        n_checks++; if (bus.perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", bus.perr); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
        reset = 1'b0;
        step(2);
        n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL reset_rxrdy_after: got %b expected 0", bus.rxrdy); end
    endtask

    task automatic test_basic_timing();
        int c0;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        rise_cyc = -1; watch = 1'b1;
        c0 = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        step(4);
        watch = 1'b0;
        n_checks++; if (rise_cyc !== c0 + 155) begin n_fail++; $display("FAIL basic_rxrdy_cycle: got %0d expected %0d", rise_cyc - c0, 155); end
        n_checks++; if (bus.data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", bus.data); end
        n_checks++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b expected 0", bus.ferr); end
        n_checks++; if (bus.perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b expected 0", bus.perr); end
        pop_one();
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL basic_pop_rxrdy: got %b expected 0", bus.rxrdy); end
        n_checks++; if (bus.data !== 8'h00) begin n_fail++; $display("FAIL basic_pop_data: got %h expected 00", bus.data); end
    endtask

    task automatic test_parity();
        eight = 1'b1; pen = 1'b1; ohel = 1'b0;
        send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1);
        step(4);
        n_checks++; if (bus.data !== 8'h03) begin n_fail++; $display("FAIL par_bad_data: got %h expected 03", bus.data); end
        n_checks++; if (bus.perr !== 1'b1) begin n_fail++; $display("FAIL par_bad_perr: got %b expected 1", bus.perr); end
        n_checks++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL par_bad_ferr: got %b expected 0", bus.ferr); end
        pop_one();
        send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1);
        step(4);
        n_checks++; if (bus.data !== 8'h03) begin n_fail++; $display("FAIL par_good_data: got %h expected 03", bus.data); end
        n_checks++; if (bus.perr !== 1'b0) begin n_fail++; $display("FAIL par_good_perr: got %b expected 0", bus.perr); end
        pop_one();
    endtask

    task automatic test_framing();
        eight = 1'b0; pen = 1'b1; ohel = 1'b1;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b0);
        step(4 * K);
        n_checks++; if (bus.data !== 8'h41) begin n_fail++; $display("FAIL frm_data: got %h expected 41", bus.data); end
        n_checks++; if (bus.perr !== 1'b0) begin n_fail++; $display("FAIL frm_perr: got %b expected 0", bus.perr); end
        n_checks++; if (bus.ferr !== 1'b1) begin n_fail++; $display("FAIL frm_ferr: got %b expected 1", bus.ferr); end
        pop_one();
        step(2 * K);
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL frm_low_line_rxrdy: got %b expected 0", bus.rxrdy); end
        n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL frm_low_line_state: got %0d expected 0", fsm_state); end
        rx = 1'b1;
        step(2 * K);
        send_frame(8'h22, 7, 1'b1, 1'b1, 1'b1);
        step(4);
        n_checks++; if (bus.data !== 8'h22) begin n_fail++; $display("FAIL frm_next_data: got %h expected 22", bus.data); end
        n_checks++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL frm_next_ferr: got %b expected 0", bus.ferr); end
        n_checks++; if (bus.perr !== 1'b0) begin n_fail++; $display("FAIL frm_next_perr: got %b expected 0", bus.perr); end
        pop_one();
    endtask

    task automatic test_false_start();
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(3 * K);
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL fstart_rxrdy: got %b expected 0", bus.rxrdy); end
        n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL fstart_state: got %0d expected 0", fsm_state); end
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        step(4);
        n_checks++; if (bus.data !== 8'h5A) begin n_fail++; $display("FAIL fstart_next_data: got %h expected 5a", bus.data); end
        n_checks++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL fstart_next_ferr: got %b expected 0", bus.ferr); end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic [7:0] e;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'h11 * (i + 1));
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
            step(4);
            if (i < 4) exp_q.push_back(d);
            if (i == 3) begin
                n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b expected 0", bus.ovf); end
            end
        end
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", bus.ovf); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.data !== e) begin n_fail++; $display("FAIL ovf_pop%0d_data: got %h expected %h", i, bus.data, e); end
            pop_one();
            if (i == 0) begin
                n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", bus.ovf); end
            end
        end
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_rxrdy: got %b expected 0", bus.rxrdy); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d;
        logic [7:0] e;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h11 * (i + 1));
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
            step(4);
            exp_q.push_back(d);
        end
        e = exp_q.pop_front();
        n_checks++; if (bus.data !== e) begin n_fail++; $display("FAIL pp_head: got %h expected %h", bus.data, e); end
        exp_q.push_back(8'h66);
        fork
            send_frame(8'h66, 8, 1'b0, 1'b0, 1'b1);
            begin
                step(154);
                bus.rd = 1'b1;
                step(1);
                bus.rd = 1'b0;
            end
        join
        step(4);
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %b expected 0", bus.ovf); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.rxrdy !== 1'b1) begin n_fail++; $display("FAIL pp_rxrdy%0d: got %b expected 1", i, bus.rxrdy); end
            n_checks++; if (bus.data !== e) begin n_fail++; $display("FAIL pp_pop%0d_data: got %h expected %h", i, bus.data, e); end
            pop_one();
        end
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL pp_drained_rxrdy: got %b expected 0", bus.rxrdy); end
    endtask

    task automatic test_reset_midframe();
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
        step(4);
        n_checks++; if (bus.data !== 8'h77) begin n_fail++; $display("FAIL rmf_pre_data: got %h expected 77", bus.data); end
        rx = 1'b0;
        step(40);
        reset = 1'b1;
        rx = 1'b1;
        step(1);
        n_checks++; if (bus.data !== 8'h00) begin n_fail++; $display("FAIL rmf_data: got %h expected 00", bus.data); end
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL rmf_rxrdy: got %b expected 0", bus.rxrdy); end
        n_checks++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL rmf_ferr: got %b expected 0", bus.ferr); end
        n_checks++; if (bus.perr !== 1'b0) begin n_fail++; $display("FAIL rmf_perr: got %b expected 0", bus.perr); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rmf_ovf: got %b expected 0", bus.ovf); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL rmf_released_rxrdy: got %b expected 0", bus.rxrdy); end
        step(10 * K + 20);
        n_checks++; if (bus.rxrdy !== 1'b0) begin n_fail++; $display("FAIL rmf_no_push: got %b expected 0", bus.rxrdy); end
        n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL rmf_state: got %0d expected 0", fsm_state); end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_parity();
        test_framing();
        test_false_start();
        test_overflow();
        test_push_pop_full();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
